uart_msg_tx: RTL
================

UART_MSG_TX -- requirements
Module: uart_msg_tx

Interface
REQ-001 Parameter: CLK_DIV, default 4, clk cycles per UART bit period; legal range is 2 or more.
REQ-002 Parameter: MAX_LEN, default 4, message buffer depth in bytes; legal range is 1 or more.
REQ-003 Parameter: LEN_W, default $clog2(MAX_LEN+1), width of the length port.
REQ-004 Port: clk  input  1  single clock; one clock domain; rising-edge logic only.
REQ-005 Port: rst  input  1  reset; asynchronous, active-high.
REQ-006 Port: start  input  1  request to transmit a message; level-sampled.
REQ-007 Port: msg  input  8*MAX_LEN  message bytes; byte k is msg[8k+7:8k]; byte 0 is sent first.
REQ-008 Port: len  input  LEN_W  number of bytes to send.
REQ-009 Port: busy  output  1  high while a message is in progress.
REQ-010 Port: done  output  1  one-cycle pulse after the last stop bit.
REQ-011 Port: tx  output  1  serial line; idles high.

Function
REQ-012 The block SHALL implement the states IDLE, START_BIT, DATA, PAR (macro only), STOP and DONE.
REQ-013 In IDLE, when start=1 and len!=0, the block SHALL latch msg and the clamped len into internal registers on that edge, and SHALL enter START_BIT.
REQ-014 A len value greater than MAX_LEN SHALL be clamped to MAX_LEN.
REQ-015 When len=0, start SHALL be ignored: the block stays in IDLE, busy stays 0 and no done pulse is produced.
REQ-016 busy SHALL be 1 in every state except IDLE; it rises on the cycle after start is accepted.
REQ-017 Each bit SHALL hold on tx for exactly CLK_DIV clk cycles, timed by a baud counter that restarts at every bit boundary.
REQ-018 Each frame SHALL be sent as: start bit 0, then 8 data bits LSB first, then [parity], then 1 stop bit.
REQ-019 The tx line SHALL be driven from a register, and the start bit SHALL appear on the cycle busy rises.
REQ-020 After a stop bit, if bytes remain, the next start bit SHALL follow immediately, with no extra idle cycles.
REQ-021 After the stop bit of the last byte, the block SHALL enter DONE for exactly one cycle, during which done=1, busy=1 and tx=1; it then returns to IDLE.
REQ-022 The total busy time SHALL be len*(10[+1])*CLK_DIV+1 cycles.
REQ-023 start SHALL be ignored while busy=1; msg and len SHALL NOT be sampled after acceptance.
REQ-024 If start=1 is held continuously, a new message SHALL be accepted in the IDLE cycle following DONE.
REQ-025 The byte counter SHALL be LEN_W bits wide and SHALL compare against the latched length, with no wrap-around.

Reset
REQ-026 While rst=1, asynchronously: the state SHALL be IDLE, tx=1, busy=0, done=0, and all counters and latched data SHALL be 0.
REQ-027 A reset asserted mid-frame SHALL abort the message immediately, with tx forced to 1 and no done pulse.
REQ-028 After reset is released, the block SHALL accept start on the first rising edge.

Configuration
REQ-029 Macro UART_MSG_TX_PARITY_EN, when defined, SHALL add the PAR state, which sends an even-parity bit (the XOR of the 8 data bits) between the data and stop bits, making an 11-bit frame.
REQ-030 When UART_MSG_TX_PARITY_EN is not defined, there SHALL be no PAR state and no parity logic, and frames SHALL be 10 bits.

Verification
REQ-031 Scenario, CLK_DIV=4, MAX_LEN=4, no parity: msg bytes 0x41,0x42 with len=2 and a start pulse -> tx carries 0,1000 0010,1 then 0,0100 0010,1, each bit 4 cycles; busy lasts 81 cycles; done pulses once.
REQ-032 Scenario, same configuration: len=0 with start held high for 10 cycles -> busy=0, tx=1 and done=0 throughout.
REQ-033 Scenario, same configuration: len=7 with a start pulse -> exactly 4 frames are sent, carrying bytes 0..3.
REQ-034 Scenario, same configuration: start re-pulsed with a new msg during frame 1 -> the original bytes are sent unchanged and only one done pulse occurs.
REQ-035 Scenario, same configuration: rst asserted in the middle of the data bits of byte 0 -> tx=1 and busy=0 within the same cycle; no done pulse; a subsequent start sends a correct frame.
REQ-036 Scenario, with UART_MSG_TX_PARITY_EN defined: bytes 0x07 and 0x03 -> parity bits 1 and 0; each frame is 44 cycles.

Source files
------------

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: sends a latched message of up to MAX_LEN bytes as 8N1 UART frames (8E1 with UART_MSG_TX_PARITY_EN)
// Ports: clk, rst (async active-high), start (level), msg (byte k at [8k+7:8k], byte 0 first), len (clamped to MAX_LEN),
//        busy (high outside IDLE), done (one-cycle pulse after the last stop bit), tx (registered serial line, idles high).
// Optional macro UART_MSG_TX_PARITY_EN adds an even-parity bit between the data and stop bits.
module uart_msg_tx #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 4,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*MAX_LEN-1:0]   msg,
  input  logic [LEN_W-1:0]       len,
  output logic                   busy,
  output logic                   done,
  output logic                   tx
);
  localparam int CNT_W = $clog2(CLK_DIV);
`ifdef UART_MSG_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START_BIT, DATA, PAR, STOP, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START_BIT, DATA, STOP, DONE} state_t;
`endif
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] bit_q, bit_n;
  logic [LEN_W-1:0] byte_q, byte_n, len_q, len_n;
  logic [8*MAX_LEN-1:0] msg_q, msg_n;
  logic tx_n, bit_end, last;
  assign bit_end = cnt == CNT_W'(CLK_DIV - 1);
  assign last = (byte_q + LEN_W'(1)) == len_q;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // The byte on the wire is always msg_q[7:0]; the buffer shifts down one byte per finished frame.
  always_comb begin
    state_n = state;
    byte_n = byte_q;
    msg_n = msg_q;
    len_n = len_q;
    case (state)
      IDLE: if (start && len != '0) begin
        state_n = START_BIT;
        byte_n = '0;
        msg_n = msg;
        len_n = len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len;
      end
      START_BIT: if (bit_end) state_n = DATA;
`ifdef UART_MSG_TX_PARITY_EN
      DATA: if (bit_end && bit_q == 3'd7) state_n = PAR;
      PAR: if (bit_end) state_n = STOP;
`else
      DATA: if (bit_end && bit_q == 3'd7) state_n = STOP;
`endif
      STOP: if (bit_end) begin
        state_n = last ? DONE : START_BIT;
        byte_n = last ? byte_q : byte_q + LEN_W'(1);
        msg_n = last ? msg_q : msg_q >> 8;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cnt_n = (state == IDLE || state == DONE || bit_end) ? '0 : cnt + CNT_W'(1);
    bit_n = (state == DATA && bit_end) ? bit_q + 3'd1 : bit_q;
    // tx is computed for the upcoming state so the registered line changes exactly at bit boundaries.
    tx_n = state_n == START_BIT ? 1'b0 :
           state_n == DATA ? msg_n[bit_n] :
`ifdef UART_MSG_TX_PARITY_EN
           state_n == PAR ? ^msg_n[7:0] :
`endif
           1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_q <= '0;
      byte_q <= '0;
      len_q <= '0;
      msg_q <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_q <= bit_n;
      byte_q <= byte_n;
      len_q <= len_n;
      msg_q <= msg_n;
      tx <= tx_n;
    end
  end
endmodule
